// File: rtl/op_deser_pkg.sv
// op_deser_pkg: shared types, width limits and width helpers for the
// op_deser serial-to-word deserializer.
package op_deser_pkg;

    // Legal WIDTH range; checked at elaboration in the top.
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Output holding-register state.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ostate_e;

    // Bits needed to hold a ones count of 0..w inclusive.
    function automatic int cw_of(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/op_deser_if.sv
// op_deser_if: serial input, flush, and word valid/ready output bundle.
// With OP_DESER_PARITY_EN defined the bundle also carries word_par.
interface op_deser_if
    import op_deser_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int CW = cw_of(WIDTH);
    localparam int BW = $clog2(WIDTH);

    logic             bit_in;
    logic             bit_vld;
    logic             clr;
    logic [WIDTH-1:0] word_out;
    logic             word_vld;
    logic             word_rdy;
    logic [CW-1:0]    ones_cnt;
    logic [BW-1:0]    bit_cnt;
    logic             ovf;
`ifdef OP_DESER_PARITY_EN
    logic             word_par;
`endif

    // Producer of bits / consumer of words.
    modport master (
        output bit_in, bit_vld, clr, word_rdy,
        input  word_out, word_vld, ones_cnt, bit_cnt, ovf
`ifdef OP_DESER_PARITY_EN
        , input word_par
`endif
    );

    // The deserializer itself.
    modport slave (
        input  bit_in, bit_vld, clr, word_rdy,
        output word_out, word_vld, ones_cnt, bit_cnt, ovf
`ifdef OP_DESER_PARITY_EN
        , output word_par
`endif
    );

endinterface

// File: rtl/op_deser_shift.sv
// op_deser_shift: fill path. Shifts qualified bits into a word, tracks the
// bit position and a running ones count, and flags the completing bit with
// a combinational done pulse so the top can load on that same edge.
module op_deser_shift
    import op_deser_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  bit MSB_FIRST = 1'b1,
    localparam int CW        = cw_of(WIDTH),
    localparam int BW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             bit_in,
    input  logic             bit_vld,
    output logic [BW-1:0]    bit_cnt,
    output logic             done,
    output logic [WIDTH-1:0] done_word,
    output logic [CW-1:0]    done_ones
);

    logic [WIDTH-1:0] sh_q;
    logic [BW-1:0]    cnt_q;
    logic [CW-1:0]    ones_q;
    logic             last;

    // MSB-first pushes in at bit 0 so the first bit ends at the top;
    // LSB-first pushes in at the top so the first bit ends at bit 0.
    if (MSB_FIRST) begin : g_msb
        assign done_word = {sh_q[WIDTH-2:0], bit_in};
    end else begin : g_lsb
        assign done_word = {bit_in, sh_q[WIDTH-1:1]};
    end

    assign last      = (cnt_q == BW'(WIDTH - 1));
    assign done_ones = ones_q + CW'(bit_in);
    // A bit arriving with clr is discarded, so it cannot complete a word.
    assign done      = bit_vld & ~clr & last;
    assign bit_cnt   = cnt_q;

    // Fill state: advance on each qualified bit, restart after the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            ones_q <= '0;
        end else if (clr) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            ones_q <= '0;
        end else if (bit_vld) begin
            sh_q <= done_word;
            if (last) begin
                cnt_q  <= '0;
                ones_q <= '0;
            end else begin
                cnt_q  <= cnt_q + 1'b1;
                ones_q <= done_ones;
            end
        end
    end

endmodule

// File: rtl/op_deser.sv
// op_deser: collects the single-bit op stream into WIDTH-bit words with a
// ones count and presents them through a one-entry valid/ready holding
// register. A word completing while the register is held is dropped and
// latches the sticky ovf flag.
// Optional: define OP_DESER_PARITY_EN to add word_par (XOR of word_out).
module op_deser
    import op_deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic       clk,
    input logic       rst_n,
    op_deser_if.slave bus
);

    localparam int CW = cw_of(WIDTH);
    localparam int BW = $clog2(WIDTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("op_deser: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end

    logic             done;
    logic [WIDTH-1:0] done_word;
    logic [CW-1:0]    done_ones;
    logic [BW-1:0]    bit_cnt;

    ostate_e          state_q;
    logic [WIDTH-1:0] word_q;
    logic [CW-1:0]    ones_q;
    logic             vld_q;
    logic             ovf_q;
`ifdef OP_DESER_PARITY_EN
    logic             par_q;
`endif

    op_deser_shift #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (bus.clr),
        .bit_in    (bus.bit_in),
        .bit_vld   (bus.bit_vld),
        .bit_cnt   (bit_cnt),
        .done      (done),
        .done_word (done_word),
        .done_ones (done_ones)
    );

    // Output FSM and holding register; loads on completion when the slot is
    // free or being drained this cycle, otherwise drops the word into ovf.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            word_q  <= '0;
            ones_q  <= '0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef OP_DESER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else if (bus.clr) begin
            state_q <= EMPTY;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (done) begin
                        word_q  <= done_word;
                        ones_q  <= done_ones;
`ifdef OP_DESER_PARITY_EN
                        par_q   <= ^done_word;
`endif
                        vld_q   <= 1'b1;
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (bus.word_rdy) begin
                        if (done) begin
                            word_q <= done_word;
                            ones_q <= done_ones;
`ifdef OP_DESER_PARITY_EN
                            par_q  <= ^done_word;
`endif
                        end else begin
                            vld_q   <= 1'b0;
                            state_q <= EMPTY;
                        end
                    end else if (done) begin
                        ovf_q <= 1'b1;
                    end
                end
                default: begin
                    vld_q   <= 1'b0;
                    state_q <= EMPTY;
                end
            endcase
        end
    end

    assign bus.word_out = word_q;
    assign bus.ones_cnt = ones_q;
    assign bus.word_vld = vld_q;
    assign bus.ovf      = ovf_q;
    assign bus.bit_cnt  = bit_cnt;
`ifdef OP_DESER_PARITY_EN
    assign bus.word_par = par_q;
`endif

endmodule

// File: tb/tb_op_deser.sv
// tb_op_deser: drives one bit stream into an MSB-first and an LSB-first
// op_deser (WIDTH=8). A queue-based model of the word/holding-register
// rules pushes expected words; a negedge monitor pops them on handshakes.
module tb_op_deser;

    localparam int W = 8;

    typedef struct {
        int m;
        int l;
        int ones;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bi = 1'b0, bv = 1'b0, cl = 1'b0, rdy = 1'b0;

    always #5 clk = ~clk;

    op_deser_if #(.WIDTH(W)) bus_m ();
    op_deser_if #(.WIDTH(W)) bus_l ();

    assign bus_m.bit_in   = bi;
    assign bus_m.bit_vld  = bv;
    assign bus_m.clr      = cl;
    assign bus_m.word_rdy = rdy;
    assign bus_l.bit_in   = bi;
    assign bus_l.bit_vld  = bv;
    assign bus_l.clr      = cl;
    assign bus_l.word_rdy = rdy;

    op_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst_n(rst_n), .bus(bus_m));
    op_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(bus_l));

    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    bit   stop_mon = 1'b0;

    // Reference model state
    int   cur[$];
    exp_t q[$];
    bit   full_m = 1'b0;
    bit   ovf_m  = 1'b0;

    task automatic chk(input string n, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", n, act, act, exp, exp);
    endtask

    function automatic exp_t make_word();
        exp_t e;
        e.m = 0; e.l = 0; e.ones = 0;
        for (int i = 0; i < cur.size(); i++) begin
            e.m    = e.m * 2 + cur[i];
            e.l    = e.l + (cur[i] << i);
            e.ones = e.ones + cur[i];
        end
        return e;
    endfunction

    task automatic model_reset();
        cur.delete();
        q.delete();
        full_m = 1'b0;
        ovf_m  = 1'b0;
    endtask

    // Effect of one clock edge with the given inputs.
    task automatic model_edge(input bit b, input bit v, input bit c, input bit r);
        bit   cmp;
        exp_t e;
        if (c) begin
            cur.delete();
            if (full_m) void'(q.pop_back());
            full_m = 1'b0;
            ovf_m  = 1'b0;
        end else begin
            cmp = v && (cur.size() == W - 1);
            if (v) cur.push_back(int'(b));
            if (full_m && r) full_m = 1'b0;
            if (cmp) begin
                e = make_word();
                if (!full_m) begin
                    full_m = 1'b1;
                    q.push_back(e);
                end else begin
                    ovf_m = 1'b1;
                end
                cur.delete();
            end
        end
    endtask

    task automatic step(input bit b, input bit v, input bit c, input bit r);
        bi = b; bv = v; cl = c; rdy = r;
        @(posedge clk);
        #2;
        model_edge(b, v, c, r);
    endtask

    // Send 8 bits, first bit = val[7]; optional idle cycle after each bit.
    task automatic send_word(input logic [7:0] val, input bit gap, input bit r_body, input bit r_last);
        for (int i = 7; i >= 0; i--) begin
            step(val[i], 1'b1, 1'b0, (i == 0) ? r_last : r_body);
            if (gap && i != 0) step(1'b0, 1'b0, 1'b0, r_body);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_vld"},  int'(bus_m.word_vld) + int'(bus_l.word_vld), 0);
        chk({tag, "_ovf"},  int'(bus_m.ovf) + int'(bus_l.ovf), 0);
        chk({tag, "_bcnt"}, int'(bus_m.bit_cnt) + int'(bus_l.bit_cnt), 0);
        chk({tag, "_ones"}, int'(bus_m.ones_cnt) + int'(bus_l.ones_cnt), 0);
        chk({tag, "_word"}, int'(bus_m.word_out) + int'(bus_l.word_out), 0);
    endtask

    // Monitor: per-cycle state compare, word compare on each handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !stop_mon) begin
            chk("vld_m",  int'(bus_m.word_vld), int'(full_m));
            chk("vld_l",  int'(bus_l.word_vld), int'(full_m));
            chk("ovf_m",  int'(bus_m.ovf), int'(ovf_m));
            chk("ovf_l",  int'(bus_l.ovf), int'(ovf_m));
            chk("bcnt_m", int'(bus_m.bit_cnt), cur.size());
            chk("bcnt_l", int'(bus_l.bit_cnt), cur.size());
            if (bus_m.word_vld && bus_m.word_rdy && !bus_m.clr) begin
                if (q.size() == 0) begin
                    chk("sb_nonempty", 0, 1);
                end else begin
                    e = q.pop_front();
                    chk("word_m", int'(bus_m.word_out), e.m);
                    chk("word_l", int'(bus_l.word_out), e.l);
                    chk("ones_m", int'(bus_m.ones_cnt), e.ones);
                    chk("ones_l", int'(bus_l.ones_cnt), e.ones);
`ifdef OP_DESER_PARITY_EN
                    chk("par_m", int'(bus_m.word_par), e.ones % 2);
                    chk("par_l", int'(bus_l.word_par), e.ones % 2);
`endif
                end
            end
        end
    end

    initial begin
        int p_rdy;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_checks("rst");
        model_reset();
        rst_n = 1'b1;

        // Basic word 0xB2 / 0x4D, consumer always ready
        send_word(8'hB2, 1'b0, 1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
        // Same bits with gaps
        send_word(8'hB2, 1'b1, 1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
        // Parity-odd word
        send_word(8'hB3, 1'b0, 1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure overflow: 0xFF held, 0x00 dropped
        send_word(8'hFF, 1'b0, 1'b0, 1'b0);
        send_word(8'h00, 1'b0, 1'b0, 1'b0);
        chk("ovf_after16", int'(bus_m.ovf), 1);
        chk("held_ff", int'(bus_m.word_out), 8'hFF);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf_sticky", int'(bus_m.ovf), 1);

        // Clear, then back-to-back accept on the last bit of the next word
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send_word(8'h5A, 1'b0, 1'b0, 1'b0);
        send_word(8'hC3, 1'b0, 1'b0, 1'b1);
        chk("b2b_word", int'(bus_m.word_out), 8'hC3);
        chk("b2b_ovf", int'(bus_m.ovf), 0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Async reset after 5 bits
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        bv = 1'b0;
        rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // clr together with a valid bit after an overflow
        send_word(8'h81, 1'b0, 1'b0, 1'b0);
        send_word(8'h7E, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr_bcnt", int'(bus_m.bit_cnt), 0);
        chk("clr_ovf", int'(bus_m.ovf), 0);
        send_word(8'h3C, 1'b0, 1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic with varying consumer readiness
        for (int blk = 0; blk < 6; blk++) begin
            p_rdy = 20 + 15 * blk;
            for (int c = 0; c < 500; c++) begin
                step(1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 199) == 0),
                     1'($urandom_range(0, 99) < p_rdy));
            end
        end

        // Drain
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        stop_mon = 1'b1;
        chk("drain_empty", q.size(), 0);
        chk("drain_vld", int'(bus_m.word_vld) + int'(bus_l.word_vld), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/op_deser.md
Name: op_deser

Overview:
- Downstream consumer of the registered single-bit `op` stream from the select/AND stage.
- Collects `op` samples, qualified by `bit_vld`, into WIDTH-bit words.
- Counts the ones in each word.
- Presents each completed word on a valid/ready output with a single holding register, flagging any word dropped under backpressure.

Parameters:
WIDTH, 8, bits per word; legal range 2..32
MSB_FIRST, 1, 1: first received bit lands in word_out[WIDTH-1]; 0: first bit lands in word_out[0]

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous assert, active-low
bit_in  input  1  serial data; connects to upstream op
bit_vld  input  1  bit_in is sampled this cycle
clr  input  1  synchronous flush
word_out  output  WIDTH  assembled word
word_vld  output  1  word_out/ones_cnt valid
word_rdy  input  1  consumer accepts word this cycle
ones_cnt  output  CW  number of 1s in word_out; CW = clog2(WIDTH+1)
bit_cnt  output  clog2(WIDTH)  bits collected toward current word
ovf  output  1  sticky: a completed word was dropped

Behaviour:
- Single clock domain. Reset is asynchronous and active-low; clk and rst_n as named.
- Reset values: word_out=0, word_vld=0, ones_cnt=0, bit_cnt=0, ovf=0, internal shift register=0, running ones count=0, FSM=EMPTY.
- Fill path, on each clk with bit_vld=1:
  - Shift bit_in into the shift register, direction per MSB_FIRST.
  - Increment the running ones count when bit_in=1.
  - Increment bit_cnt.
- Cycles with bit_vld=0 hold all fill state; gaps of any length are legal.
- Word completion occurs when bit_vld=1 and bit_cnt==WIDTH-1. On that edge:
  - bit_cnt wraps to 0 and the running ones count clears.
  - The completed word is the shift contents including this bit.
  - ones_cnt is the running count plus bit_in.
- Output FSM, two states:
  - EMPTY: word_vld=0. On completion, load word_out/ones_cnt and go to FULL. word_vld rises the cycle after the last bit (latency 1).
  - FULL: word_vld=1; word_out and ones_cnt are stable until accepted.
    - word_rdy=1, no completion: go to EMPTY.
    - word_rdy=1 and completion in the same cycle: load the new word and stay FULL (no bubble).
    - word_rdy=0 and completion: drop the new word and set ovf. Held output is unchanged; fill continues from bit_cnt=0.
- word_rdy is ignored in EMPTY.
- ovf stays set until rst_n or clr.
- clr=1 has highest priority after reset. It zeros bit_cnt, the shift register, the running count, word_vld and ovf, and sets FSM=EMPTY. A bit_vld in the same cycle is discarded.
- Reset mid-word discards the partial word; the next word starts from bit 0.
- ones_cnt never exceeds WIDTH. Arithmetic is unsigned with no saturation needed.

Optional Feature:
- Macro: OP_DESER_PARITY_EN.
- Defined:
  - Adds output port word_par (1 bit), the even parity (XOR) of word_out.
  - word_par is registered alongside word_out with identical load/hold/clear timing; reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package op_deser_pkg:
  - Output FSM state enum (EMPTY, FULL).
  - Function for CW from WIDTH.
  - Constants for the WIDTH legal min/max, used by an elaboration-time range check.
- Sub-module op_deser_shift:
  - Contains the shift register, bit_cnt and running ones count.
  - Outputs a one-cycle done pulse with the completed word and count.
  - The top holds the output FSM, holding register, ovf and the optional parity.

Test Plan:
- Basic word, WIDTH=8, MSB_FIRST=1, word_rdy=1: drive bits 1,0,1,1,0,0,1,0 on consecutive cycles -> word_out=0xB2, ones_cnt=4, word_vld high exactly one cycle, starting the cycle after the 8th bit.
- LSB-first with gaps, MSB_FIRST=0: same bit sequence with bit_vld low every other cycle -> word_out=0x4D, ones_cnt=4; bit_cnt holds during gaps.
- Backpressure overflow, word_rdy=0: send 16 bits (0xFF then 0x00) -> word_out stays 0xFF, ones_cnt=8, ovf=1 after the 16th bit. Raise word_rdy -> word_vld drops; ovf stays 1.
- Back-to-back accept: word_rdy asserted on the same edge as the next word's last bit -> word_vld stays 1 and word_out updates to the new word with no bubble; ovf=0.
- Reset/clear mid-operation:
  - Assert rst_n=0 after 5 bits -> all outputs 0 immediately.
  - Assert clr with bit_vld=1 -> bit_cnt=0 and ovf=0 next cycle.
  - The following 8 bits form a clean word.
- Parity (OP_DESER_PARITY_EN defined): word 0xB2 -> word_par=0; word 0xB3 -> word_par=1.
